// File: rtl/egress_deparser_if.sv
// Egress deparser stream bundle: action-engine beats in, AXI-Stream out.
// The slave view is the deparser; the master view drives it.
interface egress_deparser_if #(
    parameter int unsigned DATA_WIDTH = 512
);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] packet_in;
    logic [KEEP_W-1:0]     packet_keep_in;
    logic                  packet_last_in;
    logic                  packet_valid;
    logic                  packet_ready;
    logic                  drop;
    logic [8:0]            egress_port;
    logic                  header_modified;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_W-1:0]     m_axis_tkeep;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic [8:0]            m_axis_tdest;
    logic                  m_axis_tready;

    modport master (
        output packet_in, packet_keep_in, packet_last_in, packet_valid,
               drop, egress_port, header_modified, m_axis_tready,
        input  packet_ready, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
               m_axis_tvalid, m_axis_tdest
    );

    modport slave (
        input  packet_in, packet_keep_in, packet_last_in, packet_valid,
               drop, egress_port, header_modified, m_axis_tready,
        output packet_ready, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
               m_axis_tvalid, m_axis_tdest
    );
endinterface

// File: rtl/egress_deparser.sv
// Egress deparser: discards dropped packets, fixes the IPv4 header checksum on
// forwarded packets and emits AXI-Stream with the egress port on tdest.
module egress_deparser #(
    parameter int unsigned DATA_WIDTH = 512
) (
    input  logic              aclk,
    input  logic              aresetn,
    egress_deparser_if.slave  io,
    input  logic              stat_clear,
    output logic [31:0]       fwd_pkt_count,
    output logic [31:0]       drop_pkt_count,
    output logic [31:0]       csum_fix_count
);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;

    localparam logic [1:0] ST_SOP  = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DISC = 2'd2;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [8:0]            port_q;
    logic [31:0]           fwd_cnt_q;
    logic [31:0]           drop_cnt_q;
    logic [31:0]           fix_cnt_q;

    logic                  accept;
    logic                  at_sop;
    logic                  emit;
    logic                  is_ipv4;
    logic                  fix;
    logic [19:0]           sum20;
    logic [16:0]           fold1;
    logic [15:0]           fold2;
    logic [15:0]           csum;
    logic [DATA_WIDTH-1:0] data_out;

    // DISC drains regardless of the output stage; otherwise the single output
    // register must be empty or emptying.
    assign io.packet_ready = (state_q == ST_DISC) || !io.m_axis_tvalid || io.m_axis_tready;

    assign accept  = io.packet_valid && io.packet_ready;
    assign at_sop  = (state_q == ST_SOP);
    assign emit    = accept && ((at_sop && !io.drop) || (state_q == ST_FWD));
    assign is_ipv4 = (io.packet_in[8*12 +: 8] == 8'h08) &&
                     (io.packet_in[8*13 +: 8] == 8'h00) &&
                     (io.packet_in[8*14 +: 8] == 8'h45);
    assign fix     = at_sop && !io.drop && io.header_modified && is_ipv4;

    // IPv4 header checksum over bytes 14..33 with the checksum field zeroed
    always_comb begin
        sum20 = '0;
        for (int k = 0; k < 10; k++) begin
            if (k != 5) begin
                sum20 = sum20 + 20'({io.packet_in[8*(14+2*k) +: 8],
                                     io.packet_in[8*(15+2*k) +: 8]});
            end
        end
        fold1    = 17'(sum20[15:0]) + 17'(sum20[19:16]);
        fold2    = fold1[15:0] + 16'(fold1[16]);
        csum     = ~fold2;
        data_out = io.packet_in;
        if (fix) begin
            data_out[8*24 +: 8] = csum[15:8];
            data_out[8*25 +: 8] = csum[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ST_SOP: begin
                    if (!io.packet_last_in) begin
                        state_d = io.drop ? ST_DISC : ST_FWD;
                    end
                end
                default: begin
                    if (io.packet_last_in) begin
                        state_d = ST_SOP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_SOP;
            port_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept && at_sop) begin
                port_q <= io.egress_port;
            end
        end
    end

    // Single output register; holds while stalled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            io.m_axis_tvalid <= 1'b0;
            io.m_axis_tdata  <= '0;
            io.m_axis_tkeep  <= '0;
            io.m_axis_tlast  <= 1'b0;
            io.m_axis_tdest  <= '0;
        end else if (emit) begin
            io.m_axis_tvalid <= 1'b1;
            io.m_axis_tdata  <= data_out;
            io.m_axis_tkeep  <= io.packet_keep_in;
            io.m_axis_tlast  <= io.packet_last_in;
            io.m_axis_tdest  <= at_sop ? io.egress_port : port_q;
        end else if (io.m_axis_tready) begin
            io.m_axis_tvalid <= 1'b0;
        end
    end

    // Per-packet statistics; clear takes priority over a coincident event
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fix_cnt_q  <= '0;
        end else if (stat_clear) begin
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
            fix_cnt_q  <= '0;
        end else if (accept && at_sop) begin
            if (io.drop) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end else begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
                if (fix) begin
                    fix_cnt_q <= fix_cnt_q + 32'd1;
                end
            end
        end
    end

    assign fwd_pkt_count  = fwd_cnt_q;
    assign drop_pkt_count = drop_cnt_q;
    assign csum_fix_count = fix_cnt_q;

    logic unused_keep_w;
    assign unused_keep_w = (KEEP_W == 0);
endmodule

// File: tb/tb_egress_deparser.sv
// Randomized self-checking bench for egress_deparser against a queue-based
// model of the expected output stream and counters.
module tb_egress_deparser;
    localparam int unsigned DW = 512;
    localparam int unsigned KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [8:0]    dest;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        stat_clear = 1'b0;
    logic [31:0] fwd_pkt_count;
    logic [31:0] drop_pkt_count;
    logic [31:0] csum_fix_count;

    egress_deparser_if #(.DATA_WIDTH(DW)) bus ();

    egress_deparser #(.DATA_WIDTH(DW)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .io             (bus),
        .stat_clear     (stat_clear),
        .fwd_pkt_count  (fwd_pkt_count),
        .drop_pkt_count (drop_pkt_count),
        .csum_fix_count (csum_fix_count)
    );

    always #5 aclk = ~aclk;

    int          total = 0;
    int          bad = 0;
    beat_t       exp_q[$];
    beat_t       obs_q[$];
    logic [31:0] exp_fwd = '0;
    logic [31:0] exp_drop = '0;
    logic [31:0] exp_fix = '0;
    int          rdy_mode = 0;
    int          pidx = 0;
    int          stall_viol = 0;
    bit          prev_stall = 1'b0;
    beat_t       prev_out;

    // Output observer: collects handshaken beats, flags changes while stalled
    always @(negedge aclk) begin
        beat_t cur;
        cur = {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tdest};
        if (aresetn) begin
            if (prev_stall && (cur !== prev_out || bus.m_axis_tvalid !== 1'b1)) stall_viol++;
            if (bus.m_axis_tvalid && bus.m_axis_tready) obs_q.push_back(cur);
            prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
        end else begin
            prev_stall = 1'b0;
        end
        prev_out = cur;
    end

    // Downstream ready: 0 = always, 1 = random, 2 = 1,0,0,1 repeating
    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            1:       bus.m_axis_tready = 1'($urandom_range(0, 1));
            2: begin
                bus.m_axis_tready = (pidx % 4 == 0) || (pidx % 4 == 3);
                pidx++;
            end
            default: bus.m_axis_tready = 1'b1;
        endcase
    end

    function automatic logic [15:0] model_csum(input logic [DW-1:0] d);
        int unsigned sum;
        sum = 0;
        for (int k = 0; k < 10; k++)
            if (k != 5) sum += {d[8*(14+2*k) +: 8], d[8*(15+2*k) +: 8]};
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        return 16'(~sum);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int j = 0; j < int'(DW / 32); j++) d[32*j +: 32] = $urandom;
        return d;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input logic dr, input logic [8:0] p, input logic hm,
                             output int waits);
        bit acc;
        acc = 1'b0;
        bus.packet_in       = d;
        bus.packet_keep_in  = k;
        bus.packet_last_in  = l;
        bus.drop            = dr;
        bus.egress_port     = p;
        bus.header_modified = hm;
        bus.packet_valid    = 1'b1;
        waits = 0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge aclk);
            acc = bus.packet_ready;
            @(posedge aclk);
            #1;
            if (!acc) waits++;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout ready=%0b want=1", bus.packet_ready);
        end
    endtask

    // kind: 0 random header, 1 IPv4/IHL5, 2 EtherType 0x86DD
    task automatic send_pkt(input int nb, input bit dr, input logic [8:0] port,
                            input bit hm, input int kind, output int waits);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [15:0]   c;
        beat_t         e;
        int            w;
        waits = 0;
        for (int b = 0; b < nb; b++) begin
            d = rand_data();
            k = (b == nb - 1) ? (KW'({$urandom, $urandom}) | KW'(1)) : '1;
            if (b == 0 && kind == 1) begin
                d[8*12 +: 8] = 8'h08; d[8*13 +: 8] = 8'h00; d[8*14 +: 8] = 8'h45;
            end
            if (b == 0 && kind == 2) begin
                d[8*12 +: 8] = 8'h86; d[8*13 +: 8] = 8'hDD;
            end
            e = {d, k, 1'(b == nb - 1), port};
            if (b == 0) begin
                if (dr) exp_drop++;
                else begin
                    exp_fwd++;
                    if (hm && d[8*12 +: 8] == 8'h08 && d[8*13 +: 8] == 8'h00 && d[8*14 +: 8] == 8'h45) begin
                        c = model_csum(d);
                        e.data[8*24 +: 8] = c[15:8];
                        e.data[8*25 +: 8] = c[7:0];
                        exp_fix++;
                    end
                end
                send_beat(d, k, 1'(b == nb - 1), dr, port, hm, w);
            end else begin
                send_beat(d, k, 1'(b == nb - 1), 1'($urandom), 9'($urandom), 1'($urandom), w);
            end
            waits += w;
            if (!dr) exp_q.push_back(e);
        end
        bus.packet_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge aclk);
            if (obs_q.size() >= exp_q.size() && !bus.m_axis_tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", bus.m_axis_tvalid); end
        total++; if (bus.m_axis_tdata !== '0 || bus.m_axis_tkeep !== '0) begin bad++; $display("FAIL reset_tdata_tkeep got=%h/%h want=0", bus.m_axis_tdata, bus.m_axis_tkeep); end
        total++; if (bus.m_axis_tlast !== 1'b0 || bus.m_axis_tdest !== 9'd0) begin bad++; $display("FAIL reset_tlast_tdest got=%b/%h want=0/0", bus.m_axis_tlast, bus.m_axis_tdest); end
        total++; if ({fwd_pkt_count, drop_pkt_count, csum_fix_count} !== 96'd0) begin bad++; $display("FAIL reset_counters got=%h/%h/%h want=0", fwd_pkt_count, drop_pkt_count, csum_fix_count); end
        total++; if (bus.packet_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.packet_ready); end
    endtask

    task automatic test_drop;
        int w; bit ok;
        rdy_mode = 0;
        send_pkt(3, 1'b1, 9'h042, 1'b1, 1, w);
        total++; if (w !== 0) begin bad++; $display("FAIL drop_ready_stalls got=%0d want=0", w); end
        drain(ok);
        total++; if (!ok || obs_q.size() != 0) begin bad++; $display("FAIL drop_no_output beats=%0d want=0", obs_q.size()); end
        total++; if (drop_pkt_count !== exp_drop) begin bad++; $display("FAIL drop_count got=%0d want=%0d", drop_pkt_count, exp_drop); end
        total++; if (fwd_pkt_count !== exp_fwd) begin bad++; $display("FAIL drop_fwd_count got=%0d want=%0d", fwd_pkt_count, exp_fwd); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_csum_fix;
        logic [159:0]  hdr;
        logic [DW-1:0] d;
        logic [DW-1:0] want;
        logic [15:0]   got_cs;
        int w; bit ok;
        hdr = 160'h4500_0073_0000_4000_3F11_B861_C0A8_0001_C0A8_00C7;
        d = rand_data();
        d[8*12 +: 8] = 8'h08; d[8*13 +: 8] = 8'h00;
        for (int i = 0; i < 20; i++) d[8*(14+i) +: 8] = hdr[159-8*i -: 8];
        want = d;
        want[8*24 +: 8] = 8'hB9; want[8*25 +: 8] = 8'h61;
        exp_fwd++; exp_fix++;
        send_beat(d, '1, 1'b1, 1'b0, 9'd5, 1'b1, w);
        bus.packet_valid = 1'b0;
        got_cs = {bus.m_axis_tdata[8*24 +: 8], bus.m_axis_tdata[8*25 +: 8]};
        total++; if (bus.m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL csum_latency tvalid=%b want=1", bus.m_axis_tvalid); end
        total++; if (got_cs !== 16'hB961) begin bad++; $display("FAIL csum_value got=%h want=b961", got_cs); end
        total++; if (bus.m_axis_tdata !== want) begin bad++; $display("FAIL csum_other_bytes got=%h want=%h", bus.m_axis_tdata, want); end
        total++; if (bus.m_axis_tdest !== 9'd5 || bus.m_axis_tlast !== 1'b1) begin bad++; $display("FAIL csum_dest_last got=%h/%b want=005/1", bus.m_axis_tdest, bus.m_axis_tlast); end
        total++; if (csum_fix_count !== exp_fix) begin bad++; $display("FAIL csum_fix_count got=%0d want=%0d", csum_fix_count, exp_fix); end
        drain(ok);
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_non_ipv4;
        int w; bit ok;
        rdy_mode = 0;
        send_pkt(2, 1'b0, 9'h07B, 1'b1, 2, w);
        drain(ok);
        total++;
        if (!ok || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL v6_beats got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL v6_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (csum_fix_count !== exp_fix) begin bad++; $display("FAIL v6_fix_count got=%0d want=%0d", csum_fix_count, exp_fix); end
        total++; if (fwd_pkt_count !== exp_fwd) begin bad++; $display("FAIL v6_fwd_count got=%0d want=%0d", fwd_pkt_count, exp_fwd); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure;
        int w; int sv0; bit ok;
        sv0 = stall_viol;
        pidx = 0; rdy_mode = 2;
        send_pkt(4, 1'b0, 9'h1FF, 1'b1, 1, w);
        drain(ok);
        rdy_mode = 0;
        total++;
        if (!ok || obs_q.size() != 4) begin bad++; $display("FAIL bp_beats got=%0d want=4", obs_q.size()); end
        else foreach (exp_q[i]) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (stall_viol !== sv0) begin bad++; $display("FAIL bp_hold changes=%0d want=0", stall_viol - sv0); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random;
        int w; bit ok;
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 4), ($urandom_range(0, 3) == 0), 9'($urandom),
                     1'($urandom), $urandom_range(0, 2), w);
            repeat ($urandom_range(0, 2)) @(posedge aclk);
            #1;
        end
        drain(ok);
        rdy_mode = 0;
        total++;
        if (!ok || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_beats got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if ({fwd_pkt_count, drop_pkt_count, csum_fix_count} !== {exp_fwd, exp_drop, exp_fix}) begin
            bad++; $display("FAIL rand_counters got=%0d/%0d/%0d want=%0d/%0d/%0d", fwd_pkt_count, drop_pkt_count, csum_fix_count, exp_fwd, exp_drop, exp_fix);
        end
        total++; if (stall_viol !== 0) begin bad++; $display("FAIL rand_hold changes=%0d want=0", stall_viol); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_counters;
        int w; bit ok;
        @(negedge aclk);
        force dut.fwd_cnt_q = 32'hFFFF_FFFF;
        @(posedge aclk);
        #1;
        release dut.fwd_cnt_q;
        exp_fwd = 32'hFFFF_FFFF;
        send_pkt(1, 1'b0, 9'h011, 1'b0, 0, w);
        drain(ok);
        total++; if (fwd_pkt_count !== exp_fwd) begin bad++; $display("FAIL wrap_fwd got=%h want=%h", fwd_pkt_count, exp_fwd); end
        stat_clear = 1'b1;
        send_pkt(1, 1'b0, 9'h022, 1'b1, 1, w);
        stat_clear = 1'b0;
        exp_fwd = '0; exp_drop = '0; exp_fix = '0;
        total++; if ({fwd_pkt_count, drop_pkt_count, csum_fix_count} !== 96'd0) begin
            bad++; $display("FAIL clear_wins got=%0d/%0d/%0d want=0/0/0", fwd_pkt_count, drop_pkt_count, csum_fix_count);
        end
        send_pkt(1, 1'b1, 9'h033, 1'b0, 0, w);
        drain(ok);
        total++; if (drop_pkt_count !== exp_drop) begin bad++; $display("FAIL clear_resume got=%0d want=%0d", drop_pkt_count, exp_drop); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid;
        int w; bit ok;
        rdy_mode = 0;
        send_beat(rand_data(), '1, 1'b0, 1'b0, 9'h155, 1'b0, w);
        total++; if (bus.m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL rstmid_pre tvalid=%b want=1", bus.m_axis_tvalid); end
        bus.packet_in = rand_data();
        bus.packet_last_in = 1'b0;
        aresetn = 1'b0;
        #1;
        total++; if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got=%b want=0", bus.m_axis_tvalid); end
        total++; if (bus.packet_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", bus.packet_ready); end
        bus.packet_valid = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        exp_fwd = '0; exp_drop = '0; exp_fix = '0;
        exp_q.delete(); obs_q.delete();
        send_pkt(1, 1'b0, 9'h0A3, 1'b0, 0, w);
        drain(ok);
        total++;
        if (!ok || obs_q.size() != 1) begin bad++; $display("FAIL rstmid_beats got=%0d want=1", obs_q.size()); end
        else begin
            total++; if (obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL rstmid_beat got=%h want=%h", obs_q[0], exp_q[0]); end
        end
        total++; if (fwd_pkt_count !== 32'd1) begin bad++; $display("FAIL rstmid_fwd got=%0d want=1", fwd_pkt_count); end
    endtask

    initial begin
        bus.packet_in = '0;
        bus.packet_keep_in = '0;
        bus.packet_last_in = 1'b0;
        bus.packet_valid = 1'b0;
        bus.drop = 1'b0;
        bus.egress_port = '0;
        bus.header_modified = 1'b0;
        bus.m_axis_tready = 1'b1;
        #23;
        test_reset;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        test_drop;
        test_csum_fix;
        test_non_ipv4;
        test_backpressure;
        test_random;
        test_counters;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/egress_deparser.md
# egress_deparser

Egress-side consumer of the action engine's output stream. It takes the modified packet beats plus the per-packet `drop`, `egress_port` and `header_modified` results, and discards dropped packets in full. For forwarded packets it recomputes the IPv4 header checksum after TTL/MAC rewrite and emits an AXI-Stream with the egress port on `m_axis_tdest`. It sits between the action engine and the output queue/MAC and keeps per-packet statistics.

## Interface
- `DATA_WIDTH`, 512, beat width in bits. Must be ≥ 512 and a multiple of 8. Byte i occupies bits [8i+7:8i].
- `aclk` in 1: the single clock.
- `aresetn` in 1: reset. Asynchronous, active-low.
- `packet_in` in DATA_WIDTH: input beat data.
- `packet_keep_in` in DATA_WIDTH/8: input byte enables.
- `packet_last_in` in 1: last beat of the packet.
- `packet_valid` in 1: input beat valid.
- `packet_ready` out 1: input beat accepted when high together with `packet_valid`.
- `drop` in 1: per-packet drop flag, sampled on the first beat only.
- `egress_port` in 9: per-packet egress port, sampled on the first beat only.
- `header_modified` in 1: checksum-fix request, sampled on the first beat only.
- `m_axis_tdata` out DATA_WIDTH, `m_axis_tkeep` out DATA_WIDTH/8, `m_axis_tlast` out 1, `m_axis_tvalid` out 1, `m_axis_tdest` out 9: output stream.
- `m_axis_tready` in 1: downstream ready.
- `stat_clear` in 1: synchronous clear of all counters.
- `fwd_pkt_count` out 32: count of forwarded packets.
- `drop_pkt_count` out 32: count of dropped packets.
- `csum_fix_count` out 32: count of packets whose checksum was rewritten.

## Operation
- **Handshakes.** A beat is accepted when `packet_valid && packet_ready`. It is emitted when `m_axis_tvalid && m_axis_tready`.
- **States.**
  - SOP (reset state): waits for the first beat of a packet.
  - FWD: forwarding the rest of a packet.
  - DISC: discarding the rest of a packet.
- **Transitions from SOP** (on an accepted beat):
  - `drop`=1 and `packet_last_in`=0: go to DISC.
  - `drop`=0 and `packet_last_in`=0: go to FWD.
  - `packet_last_in`=1: stay in SOP, whatever `drop` is.
- **Transitions from FWD and DISC:** an accepted beat with `packet_last_in`=1 returns the FSM to SOP.
- **Per-packet latching.** The SOP beat latches `egress_port` into a tdest register. That value is applied to every output beat of the packet. `drop`, `egress_port` and `header_modified` are ignored on non-SOP beats.
- **Dropped packets.**
  - The SOP beat of a dropped packet is consumed and never emitted.
  - In DISC, beats are consumed and never emitted.
- **Output stage.** One register stage; no skid buffer.
- **Backpressure.** `packet_ready = (state==DISC) || !m_axis_tvalid || m_axis_tready`. `packet_ready` does not depend on `packet_valid`.
- **Checksum fix.** Applied on the SOP beat of a forwarded packet only when all of these hold:
  - `header_modified`=1
  - bytes 12..13 = 0x08,0x00 (EtherType IPv4)
  - byte 14 = 0x45 (IHL 5)
- **Checksum arithmetic.**
  - Words w_k = {byte[14+2k], byte[15+2k]} for k = 0..9, with w_5 (bytes 24..25) forced to 0.
  - 20-bit sum of all ten words; fold the carry twice: s = s[15:0] + s[19:16].
  - Checksum = ~s[15:0], written as byte 24 = csum[15:8], byte 25 = csum[7:0].
  - All other bytes and all keep bits pass through unchanged.
- **No fix.** If any fix condition fails, the beat passes through untouched and `csum_fix_count` does not increment.
- **Counters** (all increment on SOP-beat acceptance):
  - `fwd_pkt_count`: increments for non-dropped packets.
  - `drop_pkt_count`: increments for dropped packets.
  - `csum_fix_count`: increments when a checksum fix is applied.
  - Each counter wraps 0xFFFFFFFF → 0.
  - If `stat_clear` coincides with an increment, the clear wins: the counter becomes 0 and the event is not counted.

## Timing
- Latency: a forwarded beat accepted in cycle N appears on `m_axis_*` in cycle N+1.
- Throughput: one beat per cycle when `m_axis_tready`=1.
- **Output hold under backpressure.** While `m_axis_tvalid`=1 and `m_axis_tready`=0, all `m_axis_*` outputs hold stable.
- **Drain while stalled.** DISC beats are consumed even while the output is stalled. The held output beat is unaffected.
- **Reset values** (asynchronous; asserting `aresetn` low forces these immediately):
  - FSM = SOP.
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `m_axis_tlast`=0, `m_axis_tdest`=0.
  - All three counters = 0.
- **Reset mid-packet.** The in-flight packet is abandoned and the output may be truncated. After reset is released, the next accepted beat is treated as a SOP beat.
- **`packet_ready` during reset** follows its formula and is therefore 1.
- **Counter timing.** Counter updates are visible the cycle after the SOP beat is accepted.

## Test plan
- **Checksum fix.** Single-beat IPv4 packet with header 45 00 00 73 00 00 40 00 3F 11 B8 61 C0 A8 00 01 C0 A8 00 C7 at bytes 14..33, `header_modified`=1, `egress_port`=5 → bytes 24..25 = B9 61, `m_axis_tdest`=5, `m_axis_tlast`=1, output one cycle after acceptance, `csum_fix_count`=1.
- **Multi-beat drop.** 3-beat packet with `drop`=1 on the first beat → no output beats, `packet_ready` stays 1 throughout, `drop_pkt_count`=1, `fwd_pkt_count`=0.
- **Non-IPv4 pass-through.** EtherType 0x86DD, `header_modified`=1 → data unchanged bit for bit, `csum_fix_count` unchanged, `fwd_pkt_count`+1.
- **Backpressure.** 4-beat forwarded packet with `m_axis_tready` toggling 1,0,0,1,… → no beat lost or duplicated, outputs stable while stalled, `egress_port`=0x1FF from the SOP beat on all 4 output beats even though `egress_port` changes on later beats.
- **Counter edge cases.** Preload `fwd_pkt_count` to 0xFFFFFFFF via 2^32 packets or a force → next forwarded packet gives 0. Assert `stat_clear` together with a SOP acceptance → all counters 0.
- **Reset mid-packet.** Assert `aresetn` low during beat 2 of a 4-beat packet → `m_axis_tvalid` falls to 0 immediately. After release, a new single-beat packet is forwarded with the correct tdest and a counter value of 1.
